// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with runtime modulus, clamped step size,
// synchronous load, and a wrap/saturate boundary policy.
// Terminal-count flags are combinational from Q, mode and mod_max.
// ovf is a registered one-cycle pulse on each boundary event.
module prog_updown_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic         sat,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] mod_max,
    input  logic [N-1:0] step,
    output logic [N-1:0] Q,
    output logic         tc_up,
    output logic         tc_down,
    output logic         ovf
);

    localparam int W = N + 1;

    logic [N-1:0] s;          // effective step, never larger than mod_max
    logic [N:0]   q_ext;
    logic [N:0]   s_ext;
    logic [N:0]   max_ext;
    logic [N:0]   span;       // mod_max + 1, the wrap modulus
    logic [N:0]   up_sum;
    logic [N:0]   up_wrap;
    logic [N:0]   down_wrap;
    logic [N-1:0] q_next;
    logic         ovf_next;

    // Datapath: clamp the step and form all candidate results in N+1 bits.
    always_comb begin
        s         = (step > mod_max) ? mod_max : step;
        q_ext     = {1'b0, Q};
        s_ext     = {1'b0, s};
        max_ext   = {1'b0, mod_max};
        span      = max_ext + W'(1);
        up_sum    = q_ext + s_ext;
        up_wrap   = up_sum - span;
        // Only used when Q < s, so the result lands back inside 0..mod_max.
        down_wrap = q_ext + span - s_ext;
    end

    // Next-state selection in priority order: load, hold, recovery, count.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        q_next   = Q;
        ovf_next = 1'b0;
        if (load) begin
            q_next = (load_val > mod_max) ? mod_max : load_val;
        end else if (!en) begin
            q_next = Q;
        end else if (Q > mod_max) begin
            // mod_max was lowered below the current value: snap to the
            // boundary the counter is heading toward.
            q_next   = mode ? '0 : mod_max;
            ovf_next = 1'b1;
        end else if (mode) begin
            if (up_sum <= max_ext) begin
                q_next = up_sum[N-1:0];
            end else begin
                q_next   = sat ? mod_max : up_wrap[N-1:0];
                ovf_next = 1'b1;
            end
        end else begin
            if (Q >= s) begin
                q_next = Q - s;
            end else begin
                q_next   = sat ? '0 : down_wrap[N-1:0];
                ovf_next = 1'b1;
            end
        end
    end

    // State register: counter value and boundary pulse, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            Q   <= '0;
            ovf <= 1'b0;
        end else begin
            Q   <= q_next;
            ovf <= ovf_next;
        end
    end

    // Terminal-count flags follow Q, mode and mod_max without a clock delay.
    always_comb begin
        tc_up   = mode && (Q == mod_max);
        tc_down = !mode && (Q == '0);
    end

endmodule

// File: tb/tb_prog_updown_counter.sv
// Self-checking bench for prog_updown_counter: a directed vector table,
// hand-written reset/combinational sequences, and randomized stimulus
// compared against an arithmetic reference model.
module tb_prog_updown_counter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         mode = 1'b0;
    logic         sat = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] load_val = '0;
    logic [N-1:0] mod_max = '0;
    logic [N-1:0] step = '0;
    logic [N-1:0] Q;
    logic         tc_up;
    logic         tc_down;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    prog_updown_counter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .mod_max  (mod_max),
        .step     (step),
        .Q        (Q),
        .tc_up    (tc_up),
        .tc_down  (tc_down),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic     load;
        logic     en;
        logic     mode;
        logic     sat;
        int       load_val;
        int       mod_max;
        int       step;
        int       exp_q;
        logic     exp_ovf;
        logic     exp_tc_up;
        logic     exp_tc_down;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic add(input logic ld, input logic e, input logic m, input logic st,
                       input int lv, input int mm, input int stp,
                       input int q, input logic ov, input logic tu, input logic td);
        vec_t v;
        v.load = ld; v.en = e; v.mode = m; v.sat = st;
        v.load_val = lv; v.mod_max = mm; v.step = stp;
        v.exp_q = q; v.exp_ovf = ov; v.exp_tc_up = tu; v.exp_tc_down = td;
        vecs.push_back(v);
    endtask

    // Reference model: the counting rules expressed with plain integers.
    function automatic void model(input int q, input logic ld, input int lv, input logic e,
                                  input logic m, input logic st, input int mm, input int stp,
                                  output int qn, output logic ov);
        int s;
        s  = (stp > mm) ? mm : stp;
        ov = 1'b0;
        if (ld) begin
            qn = (lv > mm) ? mm : lv;
        end else if (!e) begin
            qn = q;
        end else if (q > mm) begin
            qn = m ? 0 : mm;
            ov = 1'b1;
        end else if (m) begin
            if (q + s <= mm) qn = q + s;
            else begin
                qn = st ? mm : (q + s) % (mm + 1);
                ov = 1'b1;
            end
        end else begin
            if (q >= s) qn = q - s;
            else begin
                qn = st ? 0 : (q - s + mm + 1) % (mm + 1);
                ov = 1'b1;
            end
        end
    endfunction

    initial begin
        int q_m;
        int q_n;
        logic ov_n;

        // ---- directed table ----
        //   ld e  m  sat lv   mm   stp  Q    ovf tcu tcd
        add(1, 0, 1, 0,   0,   9,   1,   0,   0,  0,  0);
        for (int i = 1; i <= 9; i++)
            add(0, 1, 1, 0, 0, 9, 1, i, 0, (i == 9), 0);
        add(0, 1, 1, 0,   0,   9,   1,   0,   1,  0,  0);   // wrap
        add(0, 1, 1, 0,   0,   9,   1,   1,   0,  0,  0);   // pulse gone
        add(1, 0, 1, 0,   8,   9,   3,   8,   0,  0,  0);
        add(0, 1, 1, 0,   0,   9,   3,   1,   1,  0,  0);   // 8+3 wraps to 1
        add(0, 1, 0, 0,   0,   9,   3,   8,   1,  0,  0);   // 1-3 wraps to 8
        add(0, 1, 0, 0,   0,   9,   3,   5,   0,  0,  0);
        add(1, 0, 1, 0,   2,   9,  15,   2,   0,  0,  0);
        add(0, 1, 1, 0,   0,   9,  15,   1,   1,  0,  0);   // step clamped to 9
        add(1, 0, 1, 1, 193, 200,   7, 193,   0,  0,  0);
        add(0, 1, 1, 1,   0, 200,   7, 200,   0,  1,  0);   // lands exactly
        add(0, 1, 1, 1,   0, 200,   7, 200,   1,  1,  0);   // saturated hold
        add(0, 1, 1, 1,   0, 200,   7, 200,   1,  1,  0);
        add(1, 0, 0, 1,   4, 200,   7,   4,   0,  0,  0);
        add(0, 1, 0, 1,   0, 200,   7,   0,   1,  0,  1);   // clip at zero
        add(0, 1, 0, 1,   0, 200,   7,   0,   1,  0,  1);
        add(1, 1, 1, 0,  50,  20,   1,  20,   0,  1,  0);   // load wins, clamped
        add(1, 0, 1, 0,   7,  20,   1,   7,   0,  0,  0);
        add(1, 0, 1, 0,  15,  20,   1,  15,   0,  0,  0);
        add(0, 0, 1, 0,   0,   9,   1,  15,   0,  0,  0);   // shrink, hold
        add(0, 1, 1, 0,   0,   9,   1,   0,   1,  0,  0);   // recover up
        add(1, 0, 0, 0,  15,  20,   1,  15,   0,  0,  0);
        add(0, 1, 0, 0,   0,   9,   1,   9,   1,  0,  0);   // recover down
        add(1, 0, 1, 0,   5,   0,   5,   0,   0,  1,  0);
        add(0, 1, 1, 0,   0,   0,   5,   0,   0,  1,  0);   // mod_max 0: stuck

        // ---- reset state ----
        #1 rst = 1'b1;
        #2;
        check("reset_q", Q, 0);
        check("reset_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---- table-driven vectors ----
        for (int i = 0; i < vecs.size(); i++) begin
            load = vecs[i].load; en = vecs[i].en; mode = vecs[i].mode; sat = vecs[i].sat;
            load_val = N'(vecs[i].load_val);
            mod_max = N'(vecs[i].mod_max);
            step = N'(vecs[i].step);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_q", i), Q, vecs[i].exp_q);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
            check($sformatf("vec%0d_tc_up", i), tc_up, vecs[i].exp_tc_up);
            check($sformatf("vec%0d_tc_down", i), tc_down, vecs[i].exp_tc_down);
        end

        // ---- asynchronous reset mid-count ----
        load = 1; en = 0; mode = 1; sat = 0; load_val = 37; mod_max = 255; step = 1;
        @(posedge clk);
        #1;
        load = 0;
        check("pre_reset_q", Q, 37);
        #2 rst = 1'b1;
        #1;
        check("async_reset_q", Q, 0);
        check("async_reset_ovf", ovf, 0);
        check("async_reset_tc_up", tc_up, 0);
        mode = 0;
        #1;
        check("async_reset_tc_down", tc_down, 1);
        @(negedge clk);
        rst = 1'b0;

        // ---- reset clears a live ovf pulse ----
        load = 1; mode = 1; load_val = 9; mod_max = 9; step = 1;
        @(posedge clk);
        #1;
        load = 0; en = 1;
        @(posedge clk);
        #1;
        en = 0;
        check("pulse_before_reset", ovf, 1);
        rst = 1'b1;
        #1;
        check("pulse_after_reset", ovf, 0);
        // tc flags react to mod_max between edges with no clock
        mod_max = 0;
        #1;
        check("tc_up_comb", tc_up, 1);
        @(negedge clk);
        rst = 1'b0;

        // ---- randomized stimulus against the reference model ----
        @(posedge clk);
        #1;
        q_m = 0;
        for (int c = 0; c < 3000; c++) begin
            load = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 4) != 0);
            mode = 1'($urandom);
            sat = 1'($urandom);
            load_val = N'($urandom);
            if ($urandom_range(0, 7) == 0) mod_max = N'($urandom);
            else if ($urandom_range(0, 7) == 0) mod_max = N'($urandom_range(0, 15));
            step = ($urandom_range(0, 1) == 0) ? N'($urandom_range(0, 20)) : N'($urandom);
            model(q_m, load, int'(load_val), en, mode, sat, int'(mod_max), int'(step), q_n, ov_n);
            @(posedge clk);
            #1;
            q_m = q_n;
            check("rand_q", Q, q_m);
            check("rand_ovf", ovf, ov_n);
            check("rand_tc_up", tc_up, (mode && q_m == int'(mod_max)) ? 1 : 0);
            check("rand_tc_down", tc_down, (!mode && q_m == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
